// File: rtl/md_unit_if.sv
// Issue/result bundle between the E stage and the multiply/divide unit.
interface md_unit_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 3;

    logic              start;
    logic [OP_W-1:0]   md_op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              busy;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    // E stage issues operations and reads busy/HI/LO
    modport master (
        output start, md_op, a, b,
        input  busy, hi, lo
    );

    // Multiply/divide unit side
    modport slave (
        input  start, md_op, a, b,
        output busy, hi, lo
    );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed at issue, held internally, and committed to HI/LO
// on the edge that ends the busy window.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_unit_if.slave   md
);
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned RES_W      = 2 * DATA_W;
    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   count, count_n;
    logic [RES_W-1:0]   res, res_n;
    logic               busy, busy_n;
    logic [DATA_W-1:0]  hi, hi_n;
    logic [DATA_W-1:0]  lo, lo_n;

    logic               is_arith_c;
    logic [RES_W-1:0]   arith_c;
    logic [CNT_W-1:0]   cycles_c;

    logic signed [RES_W-1:0]  sa_wide_c, sb_wide_c, prod_s_c;
    logic [RES_W-1:0]         prod_u_c;
    logic signed [DATA_W-1:0] sa_c, sb_c, sb_safe_c, quo_s_c, rem_s_c;
    logic [DATA_W-1:0]        ub_safe_c, quo_u_c, rem_u_c;
    logic                     div_zero_c, div_ovf_c;

    // 64-bit result of the arithmetic ops from the current operands
    always_comb begin
        sa_wide_c  = RES_W'($signed(md.a));
        sb_wide_c  = RES_W'($signed(md.b));
        prod_s_c   = sa_wide_c * sb_wide_c;
        prod_u_c   = {{DATA_W{1'b0}}, md.a} * {{DATA_W{1'b0}}, md.b};

        sa_c       = $signed(md.a);
        sb_c       = $signed(md.b);
        div_zero_c = (md.b == '0);
        div_ovf_c  = (md.a == 32'h8000_0000) && (md.b == 32'hFFFF_FFFF);
        // Divisors replaced by 1 in the special cases so the dividers never see them
        sb_safe_c  = (div_zero_c || div_ovf_c) ? 32'sd1 : sb_c;
        ub_safe_c  = div_zero_c ? 32'd1 : md.b;
        quo_s_c    = sa_c / sb_safe_c;
        rem_s_c    = sa_c % sb_safe_c;
        quo_u_c    = md.a / ub_safe_c;
        rem_u_c    = md.a % ub_safe_c;

        is_arith_c = 1'b0;
        arith_c    = '0;
        cycles_c   = '0;
        case (md.md_op)
            OP_MULT: begin
                is_arith_c = 1'b1;
                arith_c    = prod_s_c;
                cycles_c   = CNT_W'(MULT_CYCLES - 1);
            end
            OP_MULTU: begin
                is_arith_c = 1'b1;
                arith_c    = prod_u_c;
                cycles_c   = CNT_W'(MULT_CYCLES - 1);
            end
            OP_DIV: begin
                is_arith_c = 1'b1;
                cycles_c   = CNT_W'(DIV_CYCLES - 1);
                if (div_zero_c)
                    arith_c = {md.a, 32'hFFFF_FFFF};
                else if (div_ovf_c)
                    arith_c = {32'h0000_0000, 32'h8000_0000};
                else
                    arith_c = {rem_s_c, quo_s_c};
            end
            OP_DIVU: begin
                is_arith_c = 1'b1;
                cycles_c   = CNT_W'(DIV_CYCLES - 1);
                if (div_zero_c)
                    arith_c = {md.a, 32'hFFFF_FFFF};
                else
                    arith_c = {rem_u_c, quo_u_c};
            end
            default: begin
                is_arith_c = 1'b0;
            end
        endcase
    end

    // Next-state: issue in IDLE, count down in BUSY, commit on the last busy cycle
    always_comb begin
        state_n = state;
        count_n = count;
        res_n   = res;
        busy_n  = busy;
        hi_n    = hi;
        lo_n    = lo;
        case (state)
            IDLE: begin
                if (md.start) begin
                    if (is_arith_c) begin
                        res_n   = arith_c;
                        count_n = cycles_c;
                        busy_n  = 1'b1;
                        state_n = BUSY;
                    end else if (md.md_op == OP_MTHI) begin
                        hi_n = md.a;
                    end else if (md.md_op == OP_MTLO) begin
                        lo_n = md.a;
                    end
                end
            end
            BUSY: begin
                if (count == '0) begin
                    hi_n    = res[RES_W-1:DATA_W];
                    lo_n    = res[DATA_W-1:0];
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    count_n = count - CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State and architectural registers; reset drops any in-flight result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
            res   <= '0;
            busy  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
            res   <= res_n;
            busy  <= busy_n;
            hi    <= hi_n;
            lo    <= lo_n;
        end
    end

    assign md.busy = busy;
    assign md.hi   = hi;
    assign md.lo   = lo;
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed corner cases plus randomized
// back-to-back operations against a 64-bit arithmetic reference model.
module tb_md_unit;
    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;

    logic clk;
    logic reset;
    int   tests;
    int   failed;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_unit_if bus();

    md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {hi,lo} from plain 64-bit arithmetic
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned p;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = '0;
        case (op)
            3'd0: begin q = sa * sb; res = q; end
            3'd1: begin p = ua * ub; res = p; end
            3'd2: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            3'd3: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    p = ua / ub;
                    res[31:0] = p[31:0];
                    p = ua % ub;
                    res[63:32] = p[31:0];
                end
            end
            default: res = {m_hi, m_lo};
        endcase
        return res;
    endfunction

    // Issue one arithmetic op and follow it through busy to the commit
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp,
                          input bit toggle, input bit inject, input logic [2:0] inj_op);
        int cnt;
        int n;
        n = (op >= 3'd2) ? DIV_N : MULT_N;
        bus.start = 1'b1;
        bus.md_op = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        cnt = 0;
        while (bus.busy === 1'b1 && cnt <= 64) begin
            cnt++;
            tests++;
            if (bus.hi !== m_hi || bus.lo !== m_lo) begin
                failed++;
                $display("FAIL %s hold cyc%0d: hi=%h lo=%h expected hi=%h lo=%h", name, cnt, bus.hi, bus.lo, m_hi, m_lo);
            end
            if (toggle) begin
                bus.a = $urandom;
                bus.b = $urandom;
            end
            if (inject && cnt == 2) begin
                bus.start = 1'b1;
                bus.md_op = inj_op;
                bus.a     = $urandom;
                bus.b     = $urandom;
            end
            if (inject && cnt == 3) bus.start = 1'b0;
            @(negedge clk);
        end
        bus.start = 1'b0;
        tests++;
        if (cnt !== n) begin
            failed++;
            $display("FAIL %s busy_len: got %0d expected %0d", name, cnt, n);
        end
        tests++;
        if (bus.hi !== exp[63:32] || bus.lo !== exp[31:0]) begin
            failed++;
            $display("FAIL %s result: hi=%h lo=%h expected hi=%h lo=%h", name, bus.hi, bus.lo, exp[63:32], exp[31:0]);
        end
        m_hi = exp[63:32];
        m_lo = exp[31:0];
    endtask

    // Single-cycle MTHI/MTLO/reserved issue in IDLE
    task automatic issue_simple(input string name, input logic [2:0] op, input logic [31:0] a);
        bus.start = 1'b1;
        bus.md_op = op;
        bus.a     = a;
        bus.b     = $urandom;
        @(negedge clk);
        bus.start = 1'b0;
        if (op == 3'd4) m_hi = a;
        if (op == 3'd5) m_lo = a;
        tests++;
        if (bus.hi !== m_hi || bus.lo !== m_lo || bus.busy !== 1'b0) begin
            failed++;
            $display("FAIL %s: hi=%h lo=%h busy=%b expected hi=%h lo=%h busy=0", name, bus.hi, bus.lo, bus.busy, m_hi, m_lo);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.md_op = 3'd0;
        bus.a     = '0;
        bus.b     = '0;
        m_hi = '0;
        m_lo = '0;
        repeat (2) @(negedge clk);
        tests++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            failed++;
            $display("FAIL reset_init: busy=%b hi=%h lo=%h expected 0/0/0", bus.busy, bus.hi, bus.lo);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult();
        run_op("mult_neg3x7",  3'd0, 32'hFFFF_FFFD, 32'd7, {32'hFFFF_FFFF, 32'hFFFF_FFEB}, 1'b0, 1'b0, 3'd0);
        run_op("multu_neg3x7", 3'd1, 32'hFFFF_FFFD, 32'd7, {32'h0000_0006, 32'hFFFF_FFEB}, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic test_div();
        run_op("div_neg7by2", 3'd2, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, 1'b0, 3'd0);
        run_op("divu_7by2",   3'd3, 32'd7,         32'd2, {32'h0000_0001, 32'h0000_0003}, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic test_corners();
        run_op("div_by0",   3'd2, 32'h0000_1234, 32'd0, {32'h0000_1234, 32'hFFFF_FFFF}, 1'b0, 1'b0, 3'd0);
        run_op("divu_by0",  3'd3, 32'hDEAD_BEEF, 32'd0, {32'hDEAD_BEEF, 32'hFFFF_FFFF}, 1'b0, 1'b0, 3'd0);
        run_op("div_ovf",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic test_mt();
        issue_simple("mthi", 3'd4, 32'hAAAA_5555);
        issue_simple("mtlo", 3'd5, 32'h1357_9BDF);
        issue_simple("rsvd6", 3'd6, 32'hFFFF_0000);
        issue_simple("rsvd7", 3'd7, 32'h0F0F_0F0F);
        run_op("mtlo_in_busy", 3'd0, 32'd12345, 32'hFFFF_FF00,
               ref_md(3'd0, 32'd12345, 32'hFFFF_FF00), 1'b0, 1'b1, 3'd5);
        run_op("mthi_in_busy", 3'd3, 32'd1000, 32'd7,
               ref_md(3'd3, 32'd1000, 32'd7), 1'b0, 1'b1, 3'd4);
        run_op("div_in_busy", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               ref_md(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 1'b0, 1'b1, 3'd2);
    endtask

    task automatic test_back_to_back();
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 20; i++) begin
            op = 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 4) == 0) b = 32'd0;
            if ($urandom_range(0, 9) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
            run_op("rand_b2b", op, a, b, ref_md(op, a, b), 1'b1, 1'b0, 3'd0);
        end
    endtask

    task automatic test_reset_mid();
        issue_simple("pre_rst_mthi", 3'd4, 32'hCAFE_F00D);
        bus.start = 1'b1;
        bus.md_op = 3'd2;
        bus.a     = 32'd100;
        bus.b     = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        m_hi = '0;
        m_lo = '0;
        tests++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            failed++;
            $display("FAIL reset_async: busy=%b hi=%h lo=%h expected 0/0/0", bus.busy, bus.hi, bus.lo);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            tests++;
            if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
                failed++;
                $display("FAIL reset_no_commit cyc%0d: busy=%b hi=%h lo=%h expected 0/0/0", i, bus.busy, bus.hi, bus.lo);
            end
        end
        run_op("post_rst_mult", 3'd0, 32'd6, 32'd7, {32'd0, 32'd42}, 1'b0, 1'b0, 3'd0);
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        test_reset();
        test_mult();
        test_div();
        test_corners();
        test_mt();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
